// File: rtl/exu_brupd_queue.sv
// Branch-predictor update queue between EXU branch resolution and the IFU BHT port,
// plus a registered one-cycle fetch redirect taken from the ALU flush request.
module exu_brupd_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          res_valid,
  input  logic          res_is_br,
  input  logic [31:1]   res_pc,
  input  logic          res_ataken,
  input  logic          res_misp,
  input  logic [1:0]    res_hist,
  input  logic          res_flush_upper,
  input  logic [31:1]   res_flush_path,
  output logic          upd_valid,
  input  logic          upd_ready,
  output logic [31:1]   upd_pc,
  output logic          upd_taken,
  output logic          upd_misp,
  output logic [1:0]    upd_hist,
  output logic          fl_valid,
  output logic [31:1]   fl_path,
  output logic          q_full,
  output logic [CW-1:0] q_count,
  output logic          ovf_err
);

  localparam int PW = CW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Handshake: upd_valid is a function of registered occupancy only; head data is
  // held until the cycle where upd_valid & upd_ready are both high (a transfer).
  logic [34:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_fl_valid;
  logic [31:1]   r_fl_path;

  logic w_enq;
  logic w_deq;
  logic w_full;
  logic w_enq_acc;
  logic w_fl_set;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_enq     = res_valid & res_is_br & ~flush;
  assign w_deq     = (r_count != '0) & upd_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_enq_acc = w_enq & (~w_full | w_deq);
  assign w_fl_set  = res_valid & res_flush_upper & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_enq_acc) begin
        r_mem[r_wr_ptr] <= {res_pc, res_ataken, res_misp, res_hist};
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_enq_acc, w_deq})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_enq & w_full & ~w_deq) r_ovf <= 1'b1;
    end
  end

  // Redirect path is deliberately independent of queue occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fl_valid <= 1'b0;
      r_fl_path  <= '0;
    end else begin
      r_fl_valid <= w_fl_set;
      if (w_fl_set) r_fl_path <= res_flush_path;
    end
  end

  assign upd_valid = (r_count != '0);
  assign upd_pc    = r_mem[r_rd_ptr][34:4];
  assign upd_taken = r_mem[r_rd_ptr][3];
  assign upd_misp  = r_mem[r_rd_ptr][2];
  assign upd_hist  = r_mem[r_rd_ptr][1:0];
  assign fl_valid  = r_fl_valid;
  assign fl_path   = r_fl_path;
  assign q_full    = w_full;
  assign q_count   = r_count;
  assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_exu_brupd_queue.sv
// Self-checking bench for exu_brupd_queue: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_exu_brupd_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          res_valid = 1'b0;
  logic          res_is_br = 1'b0;
  logic [31:1]   res_pc = '0;
  logic          res_ataken = 1'b0;
  logic          res_misp = 1'b0;
  logic [1:0]    res_hist = '0;
  logic          res_flush_upper = 1'b0;
  logic [31:1]   res_flush_path = '0;
  logic          upd_ready = 1'b0;
  logic          upd_valid;
  logic [31:1]   upd_pc;
  logic          upd_taken;
  logic          upd_misp;
  logic [1:0]    upd_hist;
  logic          fl_valid;
  logic [31:1]   fl_path;
  logic          q_full;
  logic [CW-1:0] q_count;
  logic          ovf_err;

  exu_brupd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .res_valid(res_valid), .res_is_br(res_is_br), .res_pc(res_pc),
    .res_ataken(res_ataken), .res_misp(res_misp), .res_hist(res_hist),
    .res_flush_upper(res_flush_upper), .res_flush_path(res_flush_path),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_misp(upd_misp), .upd_hist(upd_hist),
    .fl_valid(fl_valid), .fl_path(fl_path),
    .q_full(q_full), .q_count(q_count), .ovf_err(ovf_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard / reference model
  logic [34:0] exp_q[$];
  logic        m_ovf;
  logic        m_fl_valid;
  logic [31:1] m_fl_path;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    chk("upd_valid", 64'(upd_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("upd_pc",    64'(upd_pc),    64'(exp_q[0][34:4]));
      chk("upd_taken", 64'(upd_taken), 64'(exp_q[0][3]));
      chk("upd_misp",  64'(upd_misp),  64'(exp_q[0][2]));
      chk("upd_hist",  64'(upd_hist),  64'(exp_q[0][1:0]));
    end
    chk("q_count",  64'(q_count),  64'(exp_q.size()));
    chk("q_full",   64'(q_full),   64'(exp_q.size() == DEPTH));
    chk("ovf_err",  64'(ovf_err),  64'(m_ovf));
    chk("fl_valid", 64'(fl_valid), 64'(m_fl_valid));
    chk("fl_path",  64'(fl_path),  64'(m_fl_path));
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ovf      = 1'b0;
    m_fl_valid = 1'b0;
    m_fl_path  = '0;
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic br, input logic [31:1] pc,
                       input logic at, input logic mp, input logic [1:0] h,
                       input logic fu, input logic [31:1] fp, input logic fl,
                       input logic rdy);
    res_valid = v; res_is_br = br; res_pc = pc; res_ataken = at; res_misp = mp;
    res_hist = h; res_flush_upper = fu; res_flush_path = fp; flush = fl;
    upd_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic enq(input logic [31:1] pc, input logic rdy);
    drive(1'b1, 1'b1, pc, pc[1], pc[2], pc[4:3], 1'b0, '0, 1'b0, rdy);
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic cycle();
    logic        e, d, f;
    logic [34:0] ent;
    e   = res_valid && res_is_br && !flush;
    d   = (exp_q.size() != 0) && upd_ready;
    f   = res_valid && res_flush_upper && !flush;
    ent = {res_pc, res_ataken, res_misp, res_hist};
    @(posedge clk); #1;
    if (e && exp_q.size() == DEPTH && !d) m_ovf = 1'b1;
    if (d) void'(exp_q.pop_front());
    if (e && (exp_q.size() < DEPTH)) exp_q.push_back(ent);
    m_fl_valid = f;
    if (f) m_fl_path = res_flush_path;
    check_outputs();
  endtask

  task automatic do_reset();
    idle(1'b0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    do_reset();
    // reset values, including the reset array feeding head data
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_upd_pc",    64'(upd_pc),    64'd0);
    chk("rst_upd_hist",  64'(upd_hist),  64'd0);
    chk("rst_q_count",   64'(q_count),   64'd0);
    chk("rst_fl_valid",  64'(fl_valid),  64'd0);
    chk("rst_fl_path",   64'(fl_path),   64'd0);
    chk("rst_ovf",       64'(ovf_err),   64'd0);

    // single branch, then accept it
    drive(1'b1, 1'b1, 31'h800, 1'b1, 1'b0, 2'b11, 1'b0, '0, 1'b0, 1'b0);
    cycle();
    chk("t1_valid", 64'(upd_valid), 64'd1);
    chk("t1_pc",    64'(upd_pc),    64'h800);
    chk("t1_taken", 64'(upd_taken), 64'd1);
    chk("t1_hist",  64'(upd_hist),  64'd3);
    idle(1'b1);
    cycle();
    chk("t1_drained", 64'(upd_valid), 64'd0);
    chk("t1_count",   64'(q_count),   64'd0);

    // overflow: fifth entry dropped
    for (int i = 1; i <= 5; i++) begin
      enq(31'(i), 1'b0);
      cycle();
      if (i == 4) chk("t2_full", 64'(q_full), 64'd1);
    end
    chk("t2_ovf", 64'(ovf_err), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", 64'(upd_pc), 64'(i));
      idle(1'b1);
      cycle();
    end
    chk("t2_empty", 64'(upd_valid), 64'd0);

    // full with simultaneous enq and deq
    do_reset();
    for (int i = 10; i <= 13; i++) begin enq(31'(i), 1'b0); cycle(); end
    enq(31'd14, 1'b1);
    cycle();
    chk("t3_count", 64'(q_count), 64'd4);
    chk("t3_ovf",   64'(ovf_err), 64'd0);
    for (int i = 11; i <= 14; i++) begin
      chk("t3_order", 64'(upd_pc), 64'(i));
      idle(1'b1);
      cycle();
    end

    // steady streaming across pointer wrap
    enq(31'h100, 1'b0); cycle();
    enq(31'h101, 1'b0); cycle();
    for (int i = 0; i < 20; i++) begin
      chk("t4_head", 64'(upd_pc), 64'(32'h100 + i));
      enq(31'(32'h102 + i), 1'b1);
      cycle();
      chk("t4_count", 64'(q_count), 64'd2);
    end
    idle(1'b1); cycle(); cycle();

    // back-to-back redirects, then a killed one
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, 31'h1000, 1'b0, 1'b0);
    cycle();
    chk("t5_fl0", 64'(fl_valid), 64'd1);
    chk("t5_fp0", 64'(fl_path),  64'h1000);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, 31'h1800, 1'b0, 1'b0);
    cycle();
    chk("t5_fl1", 64'(fl_valid), 64'd1);
    chk("t5_fp1", 64'(fl_path),  64'h1800);
    drive(1'b1, 1'b1, 31'h55, 1'b0, 1'b0, 2'b00, 1'b1, 31'h2222, 1'b1, 1'b0);
    cycle();
    chk("t5_killed_fl",  64'(fl_valid),  64'd0);
    chk("t5_killed_enq", 64'(upd_valid), 64'd0);
    chk("t5_path_hold",  64'(fl_path),   64'h1800);

    // async reset mid-operation
    enq(31'h21, 1'b0); cycle();
    enq(31'h22, 1'b0); cycle();
    drive(1'b1, 1'b1, 31'h23, 1'b0, 1'b1, 2'b01, 1'b1, 31'h3333, 1'b0, 1'b0);
    cycle();
    chk("t6_pre_count", 64'(q_count), 64'd3);
    chk("t6_pre_fl",    64'(fl_valid), 64'd1);
    idle(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(upd_valid), 64'd0);
    chk("t6_rst_count", 64'(q_count),   64'd0);
    chk("t6_rst_fl",    64'(fl_valid),  64'd0);
    chk("t6_rst_path",  64'(fl_path),   64'd0);
    chk("t6_rst_pc",    64'(upd_pc),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    enq(31'h77, 1'b0);
    cycle();
    chk("t6_new_pc",    64'(upd_pc),  64'h77);
    chk("t6_new_count", 64'(q_count), 64'd1);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 31'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 31'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
